axis_rx_monitor: RTL and testbench

AXIS_RX_MONITOR -- requirements
Module: axis_rx_monitor

---
 rtl/axis_rx_monitor.sv | 142 ++++++++++++++
 tb/tb_axis_rx_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axis_rx_monitor
// Purpose  : Passive AXI-Stream receive monitor. Once armed it counts accepted
//            beats and tlast beats, shows the data of the most recent counted
//            beat, and signals completion when a beat limit or a frame limit
//            is reached.
// Ports    : clk, rst (async, active-high)
//            s_axis_tvalid/tready/tdata/tlast : stream tap (inputs only)
//            i_rx_rcving      : arm level
//            i_datapath_rst_n : synchronous soft clear, active-low
//            i_send_len       : beat limit, 0 = unlimited
//            i_frame_num_max  : frame limit, 0 = unlimited
//            o_beat_plus      : one-cycle pulse per counted beat
//            o_beat_data      : data of the most recent counted beat
//            o_data_cnt       : counted beats since arm
//            o_tlast_cnt      : counted tlast beats since arm
//            o_rx_done        : high while in DONE
//            o_state          : IDLE=0, RUN=1, DONE=2
// Revision : 1.0 - initial release
// ============================================================================
module axis_rx_monitor #(
  parameter int TDATA_WIDTH = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   i_rx_rcving,
  input  logic                   i_datapath_rst_n,
  input  logic [CNT_WIDTH-1:0]   i_send_len,
  input  logic [CNT_WIDTH-1:0]   i_frame_num_max,
  output logic                   o_beat_plus,
  output logic [TDATA_WIDTH-1:0] o_beat_data,
  output logic [CNT_WIDTH-1:0]   o_data_cnt,
  output logic [CNT_WIDTH-1:0]   o_tlast_cnt,
  output logic                   o_rx_done,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_WIDTH-1:0]   tlast_cnt_q, tlast_cnt_d;
  logic                   beat_plus_q, beat_plus_d;
  logic [TDATA_WIDTH-1:0] beat_data_q, beat_data_d;
  logic                   beat_w;
  logic                   limit_hit_w;

  assign beat_w = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_cnt_q  <= '0;
      tlast_cnt_q <= '0;
      beat_plus_q <= 1'b0;
      beat_data_q <= '0;
    end else begin
      state_q     <= state_d;
      data_cnt_q  <= data_cnt_d;
      tlast_cnt_q <= tlast_cnt_d;
      beat_plus_q <= beat_plus_d;
      beat_data_q <= beat_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_cnt_d  = data_cnt_q;
    tlast_cnt_d = tlast_cnt_q;
    beat_plus_d = 1'b0;
    beat_data_d = beat_data_q;
    limit_hit_w = 1'b0;

    if (!i_datapath_rst_n) begin
      // Soft clear overrides every other event, including a beat this cycle.
      state_d     = ST_IDLE;
      data_cnt_d  = '0;
      tlast_cnt_d = '0;
      beat_data_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_rcving) begin
            state_d     = ST_RUN;
            data_cnt_d  = '0;
            tlast_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (beat_w) begin
            beat_plus_d = 1'b1;
            beat_data_d = s_axis_tdata;
            if (data_cnt_q != C_CNT_MAX) begin
              data_cnt_d = data_cnt_q + 1'b1;
            end
            if (s_axis_tlast && (tlast_cnt_q != C_CNT_MAX)) begin
              tlast_cnt_d = tlast_cnt_q + 1'b1;
            end
          end
          // Compare the updated counts so DONE lands with the final count;
          // equality only, so a limit lowered below the count never fires.
          limit_hit_w = ((i_send_len != '0) && (data_cnt_d == i_send_len)) ||
                        ((i_frame_num_max != '0) && (tlast_cnt_d == i_frame_num_max));
          if (limit_hit_w) begin
            state_d = ST_DONE;
          end else if (!i_rx_rcving) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!i_rx_rcving) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_beat_plus = beat_plus_q;
  assign o_beat_data = beat_data_q;
  assign o_data_cnt  = data_cnt_q;
  assign o_tlast_cnt = tlast_cnt_q;
  assign o_rx_done   = (state_q == ST_DONE);
  assign o_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_rx_monitor
// Purpose  : Directed self-checking bench for axis_rx_monitor. Expected beat
//            data is queued when a counted beat is driven and compared when
//            the DUT pulses o_beat_plus; counts and state are checked against
//            directed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_rx_monitor;

  logic        clk;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        i_rx_rcving;
  logic        i_datapath_rst_n;
  logic [31:0] i_send_len;
  logic [31:0] i_frame_num_max;
  logic        o_beat_plus;
  logic [63:0] o_beat_data;
  logic [31:0] o_data_cnt;
  logic [31:0] o_tlast_cnt;
  logic        o_rx_done;
  logic [1:0]  o_state;

  int          checks;
  int          failures;
  int          pulses;
  logic [63:0] sb[$];

  axis_rx_monitor #(
    .TDATA_WIDTH(64),
    .CNT_WIDTH  (32)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .i_rx_rcving     (i_rx_rcving),
    .i_datapath_rst_n(i_datapath_rst_n),
    .i_send_len      (i_send_len),
    .i_frame_num_max (i_frame_num_max),
    .o_beat_plus     (o_beat_plus),
    .o_beat_data     (o_beat_data),
    .o_data_cnt      (o_data_cnt),
    .o_tlast_cnt     (o_tlast_cnt),
    .o_rx_done       (o_rx_done),
    .o_state         (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; any beat pulse is
  // matched against the oldest queued expectation.
  task automatic tick();
    logic [63:0] exp_d;
    @(posedge clk);
    #1;
    if (o_beat_plus === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_d = sb.pop_front();
        chk("beat_data", o_beat_data, exp_d);
      end
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic [63:0] d,
                       input logic l, input bit counted);
    s_axis_tvalid = v;
    s_axis_tready = r;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    if (counted) sb.push_back(d);
    tick();
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_drained(input string tag);
    chk(tag, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    checks = 0; failures = 0; pulses = 0;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    i_rx_rcving = 1'b0; i_datapath_rst_n = 1'b1; i_send_len = '0; i_frame_num_max = '0;

    // Reset state
    tick(); tick();
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_data_cnt", 64'(o_data_cnt), 64'd0);
    chk("rst_tlast_cnt", 64'(o_tlast_cnt), 64'd0);
    chk("rst_beat_plus", 64'(o_beat_plus), 64'd0);
    chk("rst_beat_data", o_beat_data, 64'd0);
    chk("rst_rx_done", 64'(o_rx_done), 64'd0);
    rst = 1'b0;

    // Beat before arming is ignored
    drive(1'b1, 1'b1, 64'hDEAD, 1'b0, 1'b0);
    chk("idle_beat_ignored", 64'(o_data_cnt), 64'd0);

    // send_len=4: four back-to-back beats, DONE with the 4th count
    i_send_len = 32'd4; i_frame_num_max = '0; i_rx_rcving = 1'b1;
    idle_bus();
    chk("t1_arm_state", 64'(o_state), 64'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_not_done_yet", 64'(o_rx_done), 64'd0);
      drive(1'b1, 1'b1, 64'h1000 + 64'(i), 1'b0, 1'b1);
      chk("t1_data_cnt", 64'(o_data_cnt), 64'(i + 1));
    end
    chk("t1_rx_done", 64'(o_rx_done), 64'd1);
    chk("t1_state_done", 64'(o_state), 64'd2);
    drive(1'b1, 1'b1, 64'hBAD0, 1'b1, 1'b0);
    chk("t1_done_beat_ignored", 64'(o_data_cnt), 64'd4);
    chk("t1_pulses", 64'(pulses), 64'd4);
    i_rx_rcving = 1'b0;
    idle_bus();
    chk("t1_back_idle", 64'(o_state), 64'd0);
    chk_drained("t1_sb_empty");

    // frame_max=2: tlast on beats 3 and 5
    i_send_len = '0; i_frame_num_max = 32'd2; i_rx_rcving = 1'b1;
    idle_bus();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 64'h2000 + 64'(i), (i == 3 || i == 5), 1'b1);
      if (i == 3) chk("t2_mid_state", 64'(o_state), 64'd1);
    end
    chk("t2_tlast_cnt", 64'(o_tlast_cnt), 64'd2);
    chk("t2_data_cnt", 64'(o_data_cnt), 64'd5);
    chk("t2_done", 64'(o_rx_done), 64'd1);
    drive(1'b1, 1'b1, 64'h2006, 1'b1, 1'b0);
    chk("t2_6th_data_cnt", 64'(o_data_cnt), 64'd5);
    chk("t2_6th_tlast_cnt", 64'(o_tlast_cnt), 64'd2);
    chk("t2_6th_beat_data", o_beat_data, 64'h2005);
    i_rx_rcving = 1'b0;
    idle_bus();
    chk_drained("t2_sb_empty");

    // No limits: tready toggling for 6 cycles, then a limit lowered below count
    i_send_len = '0; i_frame_num_max = '0; i_rx_rcving = 1'b1;
    idle_bus();
    for (int i = 0; i < 6; i++) begin
      d = 64'h3000 + 64'(i);
      drive(1'b1, (i % 2 == 0), d, 1'b0, (i % 2 == 0));
    end
    idle_bus();
    chk("t3_data_cnt", 64'(o_data_cnt), 64'd3);
    chk("t3_beat_data", o_beat_data, 64'h3004);
    chk("t3_still_run", 64'(o_state), 64'd1);
    i_send_len = 32'd2;
    drive(1'b1, 1'b1, 64'h3100, 1'b0, 1'b1);
    chk("t3_below_limit_no_done", 64'(o_state), 64'd1);
    chk("t3_below_limit_cnt", 64'(o_data_cnt), 64'd4);
    i_rx_rcving = 1'b0;
    idle_bus();
    chk_drained("t3_sb_empty");

    // Arm dropped after 2 of 4 beats; the beat on the drop cycle still counts
    i_send_len = 32'd4; i_rx_rcving = 1'b1;
    idle_bus();
    drive(1'b1, 1'b1, 64'h4001, 1'b0, 1'b1);
    i_rx_rcving = 1'b0;
    drive(1'b1, 1'b1, 64'h4002, 1'b0, 1'b1);
    chk("t4_idle", 64'(o_state), 64'd0);
    chk("t4_data_cnt", 64'(o_data_cnt), 64'd2);
    chk("t4_no_done", 64'(o_rx_done), 64'd0);
    drive(1'b1, 1'b1, 64'h4003, 1'b0, 1'b0);
    chk("t4_frozen", 64'(o_data_cnt), 64'd2);
    i_rx_rcving = 1'b1;
    idle_bus();
    chk("t4_rearm_cnt", 64'(o_data_cnt), 64'd0);
    chk("t4_rearm_state", 64'(o_state), 64'd1);
    chk_drained("t4_sb_empty");

    // Asynchronous reset mid-RUN with data_cnt=7
    i_send_len = '0;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 64'h5000 + 64'(i), 1'b1, 1'b1);
    idle_bus();
    chk("t5_pre_cnt", 64'(o_data_cnt), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_state", 64'(o_state), 64'd0);
    chk("t5_async_data_cnt", 64'(o_data_cnt), 64'd0);
    chk("t5_async_tlast_cnt", 64'(o_tlast_cnt), 64'd0);
    chk("t5_async_beat_data", o_beat_data, 64'd0);
    chk("t5_async_beat_plus", 64'(o_beat_plus), 64'd0);
    chk("t5_async_rx_done", 64'(o_rx_done), 64'd0);
    tick();
    rst = 1'b0;
    idle_bus();
    chk("t5_resume_state", 64'(o_state), 64'd1);
    chk_drained("t5_sb_empty");

    // Soft clear on a beat cycle in RUN
    drive(1'b1, 1'b1, 64'h6001, 1'b0, 1'b1);
    chk("t6_pre_cnt", 64'(o_data_cnt), 64'd1);
    i_datapath_rst_n = 1'b0;
    drive(1'b1, 1'b1, 64'h6002, 1'b1, 1'b0);
    chk("t6_state", 64'(o_state), 64'd0);
    chk("t6_data_cnt", 64'(o_data_cnt), 64'd0);
    chk("t6_tlast_cnt", 64'(o_tlast_cnt), 64'd0);
    chk("t6_beat_plus", 64'(o_beat_plus), 64'd0);
    chk("t6_beat_data", o_beat_data, 64'd0);
    i_datapath_rst_n = 1'b1;
    i_rx_rcving = 1'b0;
    idle_bus();
    chk_drained("t6_sb_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
